// File: rtl/pipe_if_stage.sv
// MIPS32 instruction-fetch stage plus IF/ID register: req/ack fetch, delayed-branch redirect, stall buffering.
// Optional build macro IF_PERF_CNT_EN adds the fetch_cnt / bubble_cnt performance counters.
module pipe_if_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  input  logic        wpcir,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] dpc4,
  output logic [31:0] dinst,
  output logic        dvalid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_HAVE  = 2'b10
  } state_t;

  state_t      state, state_nx;
  logic [31:0] pc_nx, dpc4_nx, dinst_nx;
  logic        dvalid_nx;
  logic [31:0] ibuf, ibuf_nx;
  logic [31:0] redir_pc, redir_pc_nx;
  logic        redir_valid, redir_valid_nx;
  logic        load_inst, load_bubble;
  logic [31:0] pc_plus4, npc, next_pc;
  logic        redirect;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;
  // A control transfer only counts when a real instruction in ID actually advances.
  assign redirect  = dvalid & wpcir & (pcsource != 2'b00);

  always_comb begin
    npc = pc_plus4;
    case (pcsource)
      2'b00:   npc = pc_plus4;
      2'b01:   npc = bpc;
      2'b10:   npc = rpc;
      2'b11:   npc = jpc;
      default: npc = pc_plus4;
    endcase
  end

  always_comb begin
    next_pc = pc_plus4;
    if (redirect) begin
      next_pc = npc;
    end else if (redir_valid) begin
      next_pc = redir_pc;
    end else begin
      next_pc = pc_plus4;
    end
  end

  always_comb begin
    state_nx       = state;
    pc_nx          = pc;
    dpc4_nx        = dpc4;
    dinst_nx       = dinst;
    dvalid_nx      = dvalid;
    ibuf_nx        = ibuf;
    redir_pc_nx    = redir_pc;
    redir_valid_nx = redir_valid;
    load_inst      = 1'b0;
    load_bubble    = 1'b0;
    case (state)
      S_IDLE: begin
        state_nx = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          if (wpcir) begin
            load_inst = 1'b1;
          end else begin
            ibuf_nx  = imem_rdata;
            state_nx = S_HAVE;
          end
        end else if (wpcir) begin
          load_bubble = 1'b1;
          // Delay-slot fetch still outstanding: remember where to go once it lands.
          if (redirect) begin
            redir_pc_nx    = npc;
            redir_valid_nx = 1'b1;
          end else begin
            redir_pc_nx    = redir_pc;
          end
        end else begin
          state_nx = S_FETCH;
        end
      end
      S_HAVE: begin
        if (wpcir) begin
          load_inst = 1'b1;
          state_nx  = S_FETCH;
        end else begin
          state_nx  = S_HAVE;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase

    if (load_inst) begin
      dinst_nx       = (state == S_HAVE) ? ibuf : imem_rdata;
      dpc4_nx        = pc_plus4;
      dvalid_nx      = 1'b1;
      pc_nx          = next_pc;
      redir_valid_nx = 1'b0;
    end else if (load_bubble) begin
      dinst_nx  = 32'h0000_0000;
      dvalid_nx = 1'b0;
    end else begin
      dvalid_nx = dvalid;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      pc          <= PC_RESET;
      dpc4        <= 32'h0000_0000;
      dinst       <= 32'h0000_0000;
      dvalid      <= 1'b0;
      ibuf        <= 32'h0000_0000;
      redir_pc    <= 32'h0000_0000;
      redir_valid <= 1'b0;
      imem_req    <= 1'b0;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      dpc4        <= dpc4_nx;
      dinst       <= dinst_nx;
      dvalid      <= dvalid_nx;
      ibuf        <= ibuf_nx;
      redir_pc    <= redir_pc_nx;
      redir_valid <= redir_valid_nx;
      imem_req    <= (state_nx == S_FETCH);
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_cnt  <= 32'd0;
      bubble_cnt <= 32'd0;
    end else begin
      if (load_inst) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      if (load_bubble) begin
        bubble_cnt <= bubble_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_if_stage.sv
// Self-checking bench for pipe_if_stage: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a queue-based fetch/delivery model.
module tb_pipe_if_stage;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  pcsource = 2'd0;
  logic [31:0] bpc = 32'd0, rpc = 32'd0, jpc = 32'd0;
  logic        wpcir = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr, pc, dpc4, dinst;
  logic        dvalid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt, bubble_cnt;
  logic [31:0] m_fcnt, m_bcnt;
  logic [31:0] fc0, bc0;
`endif

  int total = 0;
  int bad   = 0;

  pipe_if_stage dut (
    .clock(clock), .reset(reset), .pcsource(pcsource), .bpc(bpc), .rpc(rpc), .jpc(jpc),
    .wpcir(wpcir), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .pc(pc), .dpc4(dpc4), .dinst(dinst), .dvalid(dvalid)
`ifdef IF_PERF_CNT_EN
    , .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clock = ~clock;

  // Model: words fetched but not yet handed to ID, and redirect targets still owed.
  logic [31:0] m_pc, m_dpc4, m_dinst;
  logic        m_dvalid, m_started;
  logic        m_run = 1'b0;
  logic [31:0] m_held[$];
  logic [31:0] m_pend[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pc = 32'h0000_0000; m_dpc4 = 32'd0; m_dinst = 32'd0; m_dvalid = 1'b0;
    m_started = 1'b0;
    m_held.delete(); m_pend.delete();
`ifdef IF_PERF_CNT_EN
    m_fcnt = 32'd0; m_bcnt = 32'd0;
`endif
  endfunction

  function automatic void model_step();
    logic [31:0] tgt;
    bit taken;
    if (reset) begin
      model_reset();
      return;
    end
    if (!m_started) begin
      m_started = 1'b1;
      return;
    end
    if (m_held.size() == 0 && imem_ack) m_held.push_back(imem_rdata);
    if (!wpcir) return;
    taken = m_dvalid && (pcsource != 2'd0);
    tgt = (pcsource == 2'd1) ? bpc : (pcsource == 2'd2) ? rpc : jpc;
    if (m_held.size() != 0) begin
      m_dinst  = m_held.pop_front();
      m_dpc4   = m_pc + 32'd4;
      m_dvalid = 1'b1;
      if (taken)                  m_pc = tgt;
      else if (m_pend.size() != 0) m_pc = m_pend.pop_front();
      else                        m_pc = m_pc + 32'd4;
`ifdef IF_PERF_CNT_EN
      m_fcnt = m_fcnt + 32'd1;
`endif
    end else begin
      m_dinst  = 32'd0;
      m_dvalid = 1'b0;
      if (taken) m_pend.push_back(tgt);
`ifdef IF_PERF_CNT_EN
      m_bcnt = m_bcnt + 32'd1;
`endif
    end
  endfunction

  always @(negedge clock) begin
    if (m_run) begin
      chk("pc", pc, m_pc);
      chk("imem_addr", imem_addr, m_pc);
      chk("dpc4", dpc4, m_dpc4);
      chk("dinst", dinst, m_dinst);
      chk("dvalid", {31'd0, dvalid}, {31'd0, m_dvalid});
      chk("imem_req", {31'd0, imem_req}, {31'd0, (m_started && m_held.size() == 0)});
`ifdef IF_PERF_CNT_EN
      chk("fetch_cnt", fetch_cnt, m_fcnt);
      chk("bubble_cnt", bubble_cnt, m_bcnt);
`endif
    end
  end

  task automatic cyc(input logic a, input logic [31:0] d, input logic w, input logic [1:0] s);
    imem_ack = a; imem_rdata = d; wpcir = w; pcsource = s;
    model_step();
    @(negedge clock);
    #1;
  endtask

  initial begin
    model_reset();
    m_run = 1'b1;
    cyc(1'b0, 32'd0, 1'b0, 2'd0);
    cyc(1'b1, 32'h1111_1111, 1'b1, 2'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_dinst", dinst, 32'h0);
    chk("rst_dpc4", dpc4, 32'h0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);

    // 1: streaming fetch with ack every cycle; ack in IDLE is ignored
    reset = 1'b0;
    cyc(1'b1, 32'hDEAD_BEEF, 1'b1, 2'd0);
    chk("t1_req", {31'd0, imem_req}, 32'd1);
    chk("t1_idle_dvalid", {31'd0, dvalid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("t1_addr", imem_addr, 32'(i * 4));
      cyc(1'b1, 32'hA000_0000 + 32'(i), 1'b1, 2'd0);
      chk("t1_dinst", dinst, 32'hA000_0000 + 32'(i));
      chk("t1_dvalid", {31'd0, dvalid}, 32'd1);
    end

    // 2: ack delayed three cycles
`ifdef IF_PERF_CNT_EN
    fc0 = fetch_cnt; bc0 = bubble_cnt;
`endif
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 32'h0, 1'b1, 2'd0);
      chk("t2_dvalid", {31'd0, dvalid}, 32'd0);
      chk("t2_dinst", dinst, 32'h0);
      chk("t2_pc", pc, 32'h10);
    end
    cyc(1'b1, 32'hB000_0010, 1'b1, 2'd0);
    chk("t2_dinst_late", dinst, 32'hB000_0010);
    chk("t2_pc_adv", pc, 32'h14);
`ifdef IF_PERF_CNT_EN
    chk("t2_fcnt", fetch_cnt - fc0, 32'd1);
    chk("t2_bcnt", bubble_cnt - bc0, 32'd3);
`endif

    // 3: branch while the delay-slot fetch is still outstanding
    bpc = 32'h100; rpc = 32'h200; jpc = 32'h300;
    cyc(1'b0, 32'h0, 1'b1, 2'd1);
    cyc(1'b0, 32'h0, 1'b1, 2'd1);
    chk("t3_pc_hold", pc, 32'h14);
    cyc(1'b1, 32'hC000_0014, 1'b1, 2'd0);
    chk("t3_ds_dinst", dinst, 32'hC000_0014);
    chk("t3_ds_dpc4", dpc4, 32'h18);
    chk("t3_target", imem_addr, 32'h100);

    // 4: redirects whose delay slot lands in the same cycle
    cyc(1'b1, 32'hD000_0001, 1'b1, 2'd2);
    chk("t4_jr", imem_addr, 32'h200);
    chk("t4_jr_dpc4", dpc4, 32'h104);
    cyc(1'b1, 32'hD000_0002, 1'b1, 2'd3);
    chk("t4_j", imem_addr, 32'h300);
    cyc(1'b1, 32'hD000_0003, 1'b1, 2'd1);
    chk("t4_br", imem_addr, 32'h100);
    chk("t4_br_dvalid", {31'd0, dvalid}, 32'd1);
    jpc = 32'hFFFF_FFFC;
    cyc(1'b1, 32'hD000_0004, 1'b1, 2'd3);
    chk("t4_wrap_pc", pc, 32'hFFFF_FFFC);
    cyc(1'b1, 32'hD000_0005, 1'b1, 2'd0);
    chk("t4_wrap_next", pc, 32'h0);
    chk("t4_wrap_dpc4", dpc4, 32'h0);

    // 5: stall when the ack arrives
    cyc(1'b1, 32'hE000_0000, 1'b0, 2'd0);
    chk("t5_req", {31'd0, imem_req}, 32'd0);
    chk("t5_dinst_hold", dinst, 32'hD000_0005);
    cyc(1'b1, 32'hBAD0_BAD0, 1'b0, 2'd0);
    chk("t5_dinst_hold2", dinst, 32'hD000_0005);
    cyc(1'b0, 32'h0, 1'b1, 2'd0);
    chk("t5_buffered", dinst, 32'hE000_0000);
    chk("t5_pc", imem_addr, 32'h4);
    chk("t5_req_again", {31'd0, imem_req}, 32'd1);

    // 6: reset while a fetch is outstanding with a redirect owed
    cyc(1'b0, 32'h0, 1'b1, 2'd1);
    cyc(1'b0, 32'h0, 1'b1, 2'd0);
    reset = 1'b1;
    model_reset();
    #1;
    chk("t6_pc", pc, 32'h0);
    chk("t6_req", {31'd0, imem_req}, 32'd0);
    chk("t6_dvalid", {31'd0, dvalid}, 32'd0);
    cyc(1'b1, 32'hBAD1_BAD1, 1'b1, 2'd0);
    reset = 1'b0;
    cyc(1'b1, 32'hBAD2_BAD2, 1'b1, 2'd0);
    chk("t6_addr", imem_addr, 32'h0);
    chk("t6_req_rel", {31'd0, imem_req}, 32'd1);
    chk("t6_dinst", dinst, 32'h0);
    cyc(1'b1, 32'hF000_0000, 1'b1, 2'd0);
    chk("t6_first", dinst, 32'hF000_0000);
    chk("t6_pc_adv", pc, 32'h4);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      bpc = $urandom() & 32'hFFFF_FFFC;
      rpc = $urandom() & 32'hFFFF_FFFC;
      jpc = $urandom() & 32'hFFFF_FFFC;
      reset = ($urandom_range(0, 299) == 0);
      cyc($urandom_range(0, 9) < 6, $urandom(), $urandom_range(0, 3) != 0,
          ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(1, 3)));
    end
    reset = 1'b0;
    cyc(1'b0, 32'h0, 1'b1, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
